scr1_tcm_banked: RTL and testbench

Parametrised, multi-bank tightly-coupled memory for the core's instruction (imem) and data (dmem) interfaces.
- Storage is split into NUM_BANKS single-port banks, word-interleaved, so imem and dmem proceed in parallel unless they hit the same bank.
- Bank conflicts are resolved by dmem-priority arbitration with an imem starvation guard.
- Adds error responses for out-of-range and misaligned accesses.
- Sits between core memory ports and the memory router, replacing the fixed dual-port TCM.

---
 rtl/scr1_tcm_banked_if.sv | 78 +++++++
 rtl/scr1_tcm_banked.sv | 219 +++++++++++++++++++++
 tb/tb_scr1_tcm_banked.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tcm_banked_if.sv
// -----------------------------------------------------------------------------
// scr1_mem_pkg / scr1_tcm_banked_if
//
// Purpose : Shared memory-bus enumerations and the core-side bus interface of
//           the banked TCM (imem fetch port plus dmem load/store port).
//
// Interface signals (master = core, slave = TCM):
//   imem_req      m->s  fetch request
//   imem_req_ack  s->m  fetch accepted this cycle (combinational)
//   imem_addr     m->s  fetch byte address
//   imem_rdata    s->m  fetched bank word
//   imem_resp     s->m  NOTRDY / RDY_OK / RDY_ER
//   dmem_req      m->s  data request
//   dmem_req_ack  s->m  data request accepted this cycle (combinational)
//   dmem_cmd      m->s  RD or WR
//   dmem_width    m->s  BYTE, HWORD or WORD
//   dmem_addr     m->s  data byte address
//   dmem_wdata    m->s  write data, LSB-justified
//   dmem_rdata    s->m  read data, LSB-justified
//   dmem_resp     s->m  NOTRDY / RDY_OK / RDY_ER
// -----------------------------------------------------------------------------
package scr1_mem_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

interface scr1_tcm_banked_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 64
);
    import scr1_mem_pkg::*;

    logic                 imem_req;
    logic                 imem_req_ack;
    logic [AWIDTH-1:0]    imem_addr;
    logic [DWIDTH-1:0]    imem_rdata;
    type_scr1_mem_resp_e  imem_resp;

    logic                 dmem_req;
    logic                 dmem_req_ack;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [AWIDTH-1:0]    dmem_addr;
    logic [DWIDTH-1:0]    dmem_wdata;
    logic [DWIDTH-1:0]    dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;

    modport master (
        output imem_req, imem_addr,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_req, imem_addr,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output imem_req_ack, imem_rdata, imem_resp,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/scr1_tcm_banked.sv
// -----------------------------------------------------------------------------
// scr1_tcm_banked
//
// Purpose : Tightly-coupled memory split into NUM_BANKS word-interleaved
//           single-port banks. imem and dmem run in parallel unless they hit
//           the same bank; dmem wins such conflicts unless imem has lost
//           STARVE_LIMIT conflicts in a row. Out-of-range (both ports) and
//           misaligned (dmem) accesses are acked and answered with RDY_ER
//           without touching any bank.
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of scr1_tcm_banked_if (imem and dmem ports)
// -----------------------------------------------------------------------------
module scr1_tcm_banked
    import scr1_mem_pkg::*;
#(
    parameter int unsigned TCM_SIZE     = 32'h00010000,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned DWIDTH       = 64,
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic              clk,
    input logic              rst,
    scr1_tcm_banked_if.slave bus
);

    localparam int unsigned WB      = DWIDTH / 8;
    localparam int unsigned OFF_W   = $clog2(WB);
    localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
    localparam int unsigned BANK_IW = (BANK_W > 0) ? BANK_W : 1;
    localparam int unsigned TCM_AW  = $clog2(TCM_SIZE);
    localparam int unsigned ROW_W   = TCM_AW - OFF_W - BANK_W;
    localparam int unsigned ROWS    = 1 << ROW_W;
    localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 1);

    typedef logic [BANK_IW-1:0] bank_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [OFF_W-1:0]   off_t;
    typedef logic [DWIDTH-1:0]  word_t;
    typedef logic [WB-1:0]      be_t;

    // ---------------------------------------------------------------- decode
    function automatic bank_t addr_bank(input logic [AWIDTH-1:0] addr);
        return bank_t'((addr >> OFF_W) & AWIDTH'(NUM_BANKS - 1));
    endfunction

    function automatic row_t addr_row(input logic [AWIDTH-1:0] addr);
        return row_t'(addr >> (OFF_W + BANK_W));
    endfunction

    function automatic logic out_of_range(input logic [AWIDTH-1:0] addr);
        return |(addr >> TCM_AW);
    endfunction

    // Undefined width encodings are rejected the same way as misalignment.
    function automatic logic access_err(input type_scr1_mem_width_e width,
                                        input off_t off);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 1'b0;
            SCR1_MEM_WIDTH_HWORD: return off[0];
            SCR1_MEM_WIDTH_WORD:  return |off[1:0];
            default:              return 1'b1;
        endcase
    endfunction

    bank_t            i_bank, d_bank;
    row_t             i_row, d_row;
    off_t             d_off;
    logic             i_err, d_err;
    logic             conflict, imem_turn;
    logic             i_use, d_use;
    logic [CNT_W-1:0] starve_cnt;

    // NOTE: every signal driven here gets a value before any condition, so
    // no path leaves a previous value held and no latch is inferred.
    always_comb begin
        i_bank    = addr_bank(bus.imem_addr);
        i_row     = addr_row(bus.imem_addr);
        d_bank    = addr_bank(bus.dmem_addr);
        d_row     = addr_row(bus.dmem_addr);
        d_off     = off_t'(bus.dmem_addr);
        i_err     = out_of_range(bus.imem_addr);
        d_err     = out_of_range(bus.dmem_addr) | access_err(bus.dmem_width, d_off);

        // Only requests that would really occupy a bank can collide.
        conflict  = bus.imem_req & ~i_err & bus.dmem_req & ~d_err & (i_bank == d_bank);
        imem_turn = (starve_cnt == CNT_W'(STARVE_LIMIT));

        bus.imem_req_ack = bus.imem_req & ~(conflict & ~imem_turn);
        bus.dmem_req_ack = bus.dmem_req & ~(conflict &  imem_turn);

        i_use = bus.imem_req_ack & ~i_err;
        d_use = bus.dmem_req_ack & ~d_err;
    end

    // ------------------------------------------------------- write lane prep
    // Lanes are replicated across the bank word; the byte enables pick the
    // addressed lanes. Misaligned requests never write, so a plain shift by
    // the byte offset yields the aligned mask.
    be_t   d_be;
    word_t d_wword;

    always_comb begin
        d_be    = '0;
        d_wword = '0;
        case (bus.dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                d_be    = be_t'(1) << d_off;
                d_wword = {WB{bus.dmem_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                d_be    = be_t'(2'b11) << d_off;
                d_wword = {(WB / 2){bus.dmem_wdata[15:0]}};
            end
            SCR1_MEM_WIDTH_WORD: begin
                d_be    = be_t'(4'hF) << d_off;
                d_wword = {(WB / 4){bus.dmem_wdata[31:0]}};
            end
            default: ;
        endcase
    end

    // Bits of wdata above the widest access are never stored.
    logic unused_wdata;
    assign unused_wdata = ^(bus.dmem_wdata >> 32);

    // ------------------------------------------------------------ bank ports
    // Arbitration guarantees at most one accepted user per bank per cycle.
    logic [NUM_BANKS-1:0] bank_en, bank_we;
    row_t                 bank_row [NUM_BANKS];

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]  = 1'b0;
            bank_we[b]  = 1'b0;
            bank_row[b] = i_row;
            if (d_use && d_bank == bank_t'(b)) begin
                bank_en[b]  = 1'b1;
                bank_we[b]  = (bus.dmem_cmd == SCR1_MEM_CMD_WR);
                bank_row[b] = d_row;
            end else if (i_use && i_bank == bank_t'(b)) begin
                bank_en[b]  = 1'b1;
                bank_row[b] = i_row;
            end
        end
    end

    word_t mem        [NUM_BANKS][ROWS];
    word_t bank_rdata [NUM_BANKS];

    // NOTE: storage and bank read registers are deliberately left out of
    // reset so they map onto SRAM macros; outputs are gated by reset-cleared
    // valid flags instead.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_en[b]) begin
                if (bank_we[b]) begin
                    for (int k = 0; k < WB; k++) begin
                        if (d_be[k]) mem[b][bank_row[b]][8*k +: 8] <= d_wword[8*k +: 8];
                    end
                end else begin
                    bank_rdata[b] <= mem[b][bank_row[b]];
                end
            end
        end
    end

    // ------------------------------------------------------------- responses
    type_scr1_mem_resp_e imem_resp_q, dmem_resp_q;
    logic                imem_rd_q, dmem_rd_q;
    bank_t               imem_bank_q, dmem_bank_q;
    off_t                dmem_off_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_resp_q <= SCR1_MEM_RESP_NOTRDY;
            dmem_resp_q <= SCR1_MEM_RESP_NOTRDY;
            imem_rd_q   <= 1'b0;
            dmem_rd_q   <= 1'b0;
            imem_bank_q <= '0;
            dmem_bank_q <= '0;
            dmem_off_q  <= '0;
            starve_cnt  <= '0;
        end else begin
            imem_resp_q <= SCR1_MEM_RESP_NOTRDY;
            if (bus.imem_req_ack) begin
                imem_resp_q <= i_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            end
            dmem_resp_q <= SCR1_MEM_RESP_NOTRDY;
            if (bus.dmem_req_ack) begin
                dmem_resp_q <= d_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            end
            imem_rd_q   <= i_use;
            dmem_rd_q   <= d_use & (bus.dmem_cmd == SCR1_MEM_CMD_RD);
            imem_bank_q <= i_bank;
            dmem_bank_q <= d_bank;
            dmem_off_q  <= d_off;

            // Increments only while imem loses, which stops at the limit
            // because imem then wins; any imem accept clears it.
            if (bus.imem_req_ack) begin
                starve_cnt <= '0;
            end else if (conflict && !imem_turn) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign bus.imem_resp  = imem_resp_q;
    assign bus.dmem_resp  = dmem_resp_q;
    assign bus.imem_rdata = imem_rd_q ? bank_rdata[imem_bank_q] : '0;
    assign bus.dmem_rdata = dmem_rd_q ? (bank_rdata[dmem_bank_q] >> {dmem_off_q, 3'b000}) : '0;

endmodule

// File: tb/tb_scr1_tcm_banked.sv
// -----------------------------------------------------------------------------
// tb_scr1_tcm_banked
//
// Purpose : Self-checking bench for scr1_tcm_banked. A byte-addressed memory
//           image and a conflict-loss streak form the reference; every cycle
//           the acks, and the responses of the previous cycle, are compared
//           against it. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_scr1_tcm_banked;
    import scr1_mem_pkg::*;

    localparam int unsigned TCM_SIZE     = 32'h00010000;
    localparam int unsigned NUM_BANKS    = 4;
    localparam int unsigned DWIDTH       = 64;
    localparam int unsigned AWIDTH       = 32;
    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned WB           = DWIDTH / 8;
    localparam int unsigned WIN          = 256;   // exercised address window

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scr1_tcm_banked_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

    scr1_tcm_banked #(
        .TCM_SIZE     (TCM_SIZE),
        .NUM_BANKS    (NUM_BANKS),
        .DWIDTH       (DWIDTH),
        .AWIDTH       (AWIDTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]          ref_mem [TCM_SIZE];
    int                  loss_streak = 0;
    type_scr1_mem_resp_e exp_i_resp  = SCR1_MEM_RESP_NOTRDY;
    type_scr1_mem_resp_e exp_d_resp  = SCR1_MEM_RESP_NOTRDY;
    logic [DWIDTH-1:0]   exp_i_rdata = '0;
    logic [DWIDTH-1:0]   exp_d_rdata = '0;
    logic                last_iack, last_dack;

    task automatic check(input string tag, input logic [DWIDTH-1:0] got,
                         input logic [DWIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [AWIDTH-1:0] a);
        return a < TCM_SIZE;
    endfunction

    function automatic int unsigned bank_of(input logic [AWIDTH-1:0] a);
        return (a / WB) % NUM_BANKS;
    endfunction

    function automatic int unsigned size_of(input type_scr1_mem_width_e w);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return 1;
            SCR1_MEM_WIDTH_HWORD: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit dmem_error(input logic [AWIDTH-1:0] a, input type_scr1_mem_width_e w);
        return !in_range(a) || ((a % size_of(w)) != 0);
    endfunction

    // Word containing a, shifted down by a's byte offset, upper bytes zero.
    function automatic logic [DWIDTH-1:0] ref_read(input logic [AWIDTH-1:0] a);
        logic [DWIDTH-1:0] r = '0;
        int unsigned off  = a % WB;
        for (int j = 0; j < WB; j++) begin
            if (off + j < WB) r[8*j +: 8] = ref_mem[a + j];
        end
        return r;
    endfunction

    task automatic ref_write(input logic [AWIDTH-1:0] a, input type_scr1_mem_width_e w,
                             input logic [DWIDTH-1:0] d);
        for (int j = 0; j < size_of(w); j++) ref_mem[a + j] = d[8*j +: 8];
    endtask

    task automatic idle();
        bus.imem_req   = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_req   = 1'b0;
        bus.dmem_cmd   = SCR1_MEM_CMD_RD;
        bus.dmem_width = SCR1_MEM_WIDTH_WORD;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
    endtask

    task automatic set_imem(input logic req, input logic [AWIDTH-1:0] a);
        bus.imem_req  = req;
        bus.imem_addr = a;
    endtask

    task automatic set_dmem(input logic req, input type_scr1_mem_cmd_e cmd,
                            input type_scr1_mem_width_e w, input logic [AWIDTH-1:0] a,
                            input logic [DWIDTH-1:0] d);
        bus.dmem_req   = req;
        bus.dmem_cmd   = cmd;
        bus.dmem_width = w;
        bus.dmem_addr  = a;
        bus.dmem_wdata = d;
    endtask

    // Checks the responses due this cycle and the acks for the present
    // inputs, then predicts what the next cycle must return.
    task automatic eval_cycle(output logic iack, output logic dack);
        bit i_ok, d_err, d_ok, conflict, imem_turn;
        #1;
        check("imem_resp", bus.imem_resp, exp_i_resp);
        if (exp_i_resp != SCR1_MEM_RESP_NOTRDY) check("imem_rdata", bus.imem_rdata, exp_i_rdata);
        check("dmem_resp", bus.dmem_resp, exp_d_resp);
        if (exp_d_resp != SCR1_MEM_RESP_NOTRDY) check("dmem_rdata", bus.dmem_rdata, exp_d_rdata);

        i_ok      = bus.imem_req && in_range(bus.imem_addr);
        d_err     = dmem_error(bus.dmem_addr, bus.dmem_width);
        d_ok      = bus.dmem_req && !d_err;
        conflict  = i_ok && d_ok && (bank_of(bus.imem_addr) == bank_of(bus.dmem_addr));
        imem_turn = (loss_streak >= STARVE_LIMIT);
        iack      = bus.imem_req && !(conflict && !imem_turn);
        dack      = bus.dmem_req && !(conflict && imem_turn);
        check("imem_req_ack", bus.imem_req_ack, iack);
        check("dmem_req_ack", bus.dmem_req_ack, dack);

        exp_i_resp  = SCR1_MEM_RESP_NOTRDY;
        exp_i_rdata = '0;
        if (iack) begin
            exp_i_resp  = i_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
            if (i_ok) exp_i_rdata = ref_read(bus.imem_addr & ~(AWIDTH'(WB - 1)));
        end
        exp_d_resp  = SCR1_MEM_RESP_NOTRDY;
        exp_d_rdata = '0;
        if (dack) begin
            exp_d_resp = d_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            if (!d_err) begin
                if (bus.dmem_cmd == SCR1_MEM_CMD_WR) ref_write(bus.dmem_addr, bus.dmem_width, bus.dmem_wdata);
                else                                 exp_d_rdata = ref_read(bus.dmem_addr);
            end
        end

        if (iack)          loss_streak = 0;
        else if (conflict) loss_streak = (loss_streak < STARVE_LIMIT) ? loss_streak + 1 : loss_streak;
    endtask

    task automatic step();
        eval_cycle(last_iack, last_dack);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AWIDTH-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom | 32'h0001_0000;
        return AWIDTH'($urandom_range(0, WIN - 1));
    endfunction

    initial begin
        logic hold_i, hold_d;
        logic [AWIDTH-1:0] a;
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_resp",  bus.imem_resp,  SCR1_MEM_RESP_NOTRDY);
        check("rst_dmem_resp",  bus.dmem_resp,  SCR1_MEM_RESP_NOTRDY);
        check("rst_imem_rdata", bus.imem_rdata, '0);
        check("rst_dmem_rdata", bus.dmem_rdata, '0);
        rst = 1'b0;

        // Zero the exercised window so every later read has known content.
        for (int w = 0; w < WIN; w += 4) begin
            set_dmem(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, AWIDTH'(w), '0);
            step();
        end

        // Word write then read
        set_dmem(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 64'hDEADBEEF);
        step();
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
        step();
        idle();
        check("wr_rd_resp",  bus.dmem_resp,        SCR1_MEM_RESP_RDY_OK);
        check("wr_rd_rdata", bus.dmem_rdata[31:0], 32'hDEADBEEF);
        step();

        // Byte lanes: byte 0x23 lands in the low half of word 0x20, the
        // halfword 0x26 in the upper half of the 32-bit slice at 0x24.
        set_dmem(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h23, 64'hAA);
        step();
        set_dmem(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h26, 64'h1234);
        step();
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h24, '0);
        step();
        check("lane_rd_24", bus.dmem_rdata[31:0], 32'h1234_0000);
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, '0);
        step();
        check("lane_rd_20", bus.dmem_rdata[31:0], 32'hAA00_0000);
        idle();
        step();

        // Parallel banks: imem bank 0, dmem bank 1
        set_imem(1'b1, 32'h00);
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h08, '0);
        #1;
        check("par_iack", bus.imem_req_ack, 1'b1);
        check("par_dack", bus.dmem_req_ack, 1'b1);
        step();
        idle();
        check("par_iresp", bus.imem_resp, SCR1_MEM_RESP_RDY_OK);
        check("par_dresp", bus.dmem_resp, SCR1_MEM_RESP_RDY_OK);
        step();

        // Conflict on bank 0 held continuously
        set_imem(1'b1, 32'h00);
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, '0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("starve_dack", bus.dmem_req_ack, (k < 3));
            check("starve_iack", bus.imem_req_ack, (k == 3));
            step();
        end
        // Streak cleared by the imem win: dmem takes the next conflict.
        #1;
        check("starve_clr_dack", bus.dmem_req_ack, 1'b1);
        check("starve_clr_iack", bus.imem_req_ack, 1'b0);
        step();
        set_dmem(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, '0, '0);
        step();
        idle();
        step();

        // Error responses
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0001_0000, '0);
        #1;
        check("oor_dack", bus.dmem_req_ack, 1'b1);
        step();
        idle();
        check("oor_resp",  bus.dmem_resp,  SCR1_MEM_RESP_RDY_ER);
        check("oor_rdata", bus.dmem_rdata, '0);
        set_dmem(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h11, 64'hFFFF);
        step();
        check("mis_resp", bus.dmem_resp, SCR1_MEM_RESP_RDY_ER);
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
        step();
        check("mis_unchanged", bus.dmem_rdata[31:0], 32'hDEADBEEF);
        set_dmem(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, '0, '0);
        set_imem(1'b1, 32'h0002_0000);
        step();
        check("imem_oor_resp", bus.imem_resp, SCR1_MEM_RESP_RDY_ER);
        idle();
        step();

        // Reset right after a read is accepted
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
        eval_cycle(last_iack, last_dack);
        @(posedge clk);
        #2;
        idle();
        rst = 1'b1;
        #1;
        check("rst_mid_resp",  bus.dmem_resp,  SCR1_MEM_RESP_NOTRDY);
        check("rst_mid_rdata", bus.dmem_rdata, '0);
        exp_i_resp  = SCR1_MEM_RESP_NOTRDY;
        exp_d_resp  = SCR1_MEM_RESP_NOTRDY;
        loss_streak = 0;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_resp", bus.dmem_resp, SCR1_MEM_RESP_NOTRDY);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        set_dmem(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
        step();
        check("rst_keeps_data", bus.dmem_rdata[31:0], 32'hDEADBEEF);
        idle();
        step();

        // Random traffic; a request that was not acked is held unchanged.
        hold_i = 1'b0;
        hold_d = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!hold_i) set_imem(1'($urandom_range(0, 3) != 0), rand_addr());
            if (!hold_d) begin
                type_scr1_mem_width_e w;
                w = type_scr1_mem_width_e'($urandom_range(0, 2));
                a = rand_addr();
                if ($urandom_range(0, 1) == 1) a = a & ~(AWIDTH'(size_of(w) - 1));
                set_dmem(1'($urandom_range(0, 3) != 0), type_scr1_mem_cmd_e'($urandom_range(0, 1)),
                         w, a, {$urandom, $urandom});
            end
            step();
            hold_i = bus.imem_req && !last_iack;
            hold_d = bus.dmem_req && !last_dack;
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
